// File: rtl/chunk_adder_pkg.sv
// Shared types and sizing helpers for the chunk-serial adder.
package chunk_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int nchunk(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

    // Width of the chunk index register; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_full_adder.sv
// Combinational CHUNK-bit ripple adder: two half adders plus an OR per bit.
module chunk_full_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             cm
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        logic p, g1, g2;
        assign p        = a[i] ^ b[i];
        assign g1       = a[i] & b[i];
        assign s[i]     = p ^ c[i];
        assign g2       = p & c[i];
        assign c[i+1]   = g1 | g2;
    end

    assign co = c[CHUNK];
    assign cm = c[CHUNK-1];

endmodule

// File: rtl/chunk_serial_adder.sv
// Sequential A+B+cin adder, CHUNK bits per clock with valid/ready on both sides.
// Define CHUNK_ADDER_SUB_EN to add a 'sub' port selecting A-B.
module chunk_serial_adder
    import chunk_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef CHUNK_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int PW     = NCHUNK * CHUNK;
    localparam int IW     = idx_width(NCHUNK);
    localparam int LB     = WIDTH - (NCHUNK - 1) * CHUNK;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    state_t          state;
    logic [IW-1:0]   idx;
    logic [PW-1:0]   a_r, b_r, sum_pad, sum_nxt;
    logic            carry;
    logic [CHUNK-1:0] ca, cb, s;
    logic            co, cm, top_co, top_cm;
    logic [WIDTH-1:0] b_in;
    logic            c_in;

`ifdef CHUNK_ADDER_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    always_comb begin
        ca      = '0;
        cb      = '0;
        sum_nxt = sum_pad;
        for (int j = 0; j < NCHUNK; j++) begin
            if (idx == IW'(j)) begin
                ca = a_r[j*CHUNK +: CHUNK];
                cb = b_r[j*CHUNK +: CHUNK];
                sum_nxt[j*CHUNK +: CHUNK] = s;
            end
        end
    end

    chunk_full_adder #(.CHUNK(CHUNK)) u_fa (
        .a  (ca),
        .b  (cb),
        .ci (carry),
        .s  (s),
        .co (co),
        .cm (cm)
    );

    // A partial last chunk has zero padding above the MSB, so the carry out of
    // bit WIDTH-1 lands in sum bit LB and the carry into it is recovered from a^b^s.
    assign top_co = (LB == CHUNK) ? co : s[LB % CHUNK];
    assign top_cm = (LB == CHUNK) ? cm : (ca[LB-1] ^ cb[LB-1] ^ s[LB-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            carry     <= 1'b0;
            sum_pad   <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_r      <= PW'(a);
                        b_r      <= PW'(b_in);
                        carry    <= c_in;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum_pad <= sum_nxt;
                    carry   <= co;
                    idx     <= idx + 1'b1;
                    if (idx == LAST) begin
                        cout      <= top_co;
                        overflow  <= top_cm ^ top_co;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sum = sum_pad[WIDTH-1:0];

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed bench: 16/4 and 10/4 instances, vector table plus handshake/reset sequences.
module tb_chunk_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 16-bit / 4-bit instance
    logic        v16 = 0, r16, ov16, ord16 = 0, c16 = 0, s16 = 0, co16, of16;
    logic [15:0] a16 = 0, b16 = 0, sum16;
    // 10-bit / 4-bit instance
    logic        v10 = 0, r10, ov10, ord10 = 0, c10 = 0, s10 = 0, co10, of10;
    logic [9:0]  a10 = 0, b10 = 0, sum10;

    chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .a(a16), .b(b16),
`ifdef CHUNK_ADDER_SUB_EN
        .sub(s16),
`endif
        .cin(c16), .out_valid(ov16), .out_ready(ord16), .sum(sum16),
        .cout(co16), .overflow(of16));

    chunk_serial_adder #(.WIDTH(10), .CHUNK(4)) u10 (
        .clk(clk), .rst(rst), .in_valid(v10), .in_ready(r10), .a(a10), .b(b10),
`ifdef CHUNK_ADDER_SUB_EN
        .sub(s10),
`endif
        .cin(c10), .out_valid(ov10), .out_ready(ord10), .sum(sum10),
        .cout(co10), .overflow(of10));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic op16(input logic [15:0] ta, tb, input logic tc, ts, output int lat);
        int n = 0;
        while (!r16 && n < 50) begin @(posedge clk); #1; n++; end
        if (!r16) chk("in_ready16 timeout", 0, 1);
        a16 = ta; b16 = tb; c16 = tc; s16 = ts; v16 = 1;
        @(posedge clk); #1;
        // scramble inputs after acceptance
        v16 = 0; a16 = 16'hA5C3; b16 = 16'h3C5A; c16 = ~tc; s16 = ~ts;
        lat = 0;
        while (!ov16 && lat < 50) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic op10(input logic [9:0] ta, tb, input logic tc, output int lat);
        int n = 0;
        while (!r10 && n < 50) begin @(posedge clk); #1; n++; end
        if (!r10) chk("in_ready10 timeout", 0, 1);
        a10 = ta; b10 = tb; c10 = tc; v10 = 1;
        @(posedge clk); #1;
        v10 = 0; a10 = 10'h155; b10 = 10'h2AA; c10 = ~tc;
        lat = 0;
        while (!ov10 && lat < 50) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic drain16();
        ord16 = 1; @(posedge clk); #1; ord16 = 0;
    endtask

    task automatic drain10();
        ord10 = 1; @(posedge clk); #1; ord10 = 0;
    endtask

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] sum;
        logic        cout, ovf;
    } vec16_t;

    typedef struct {
        logic [9:0] a, b;
        logic       cin;
        logic [9:0] sum;
        logic       cout, ovf;
    } vec10_t;

`ifdef CHUNK_ADDER_SUB_EN
    localparam int NV16 = 11;
`else
    localparam int NV16 = 8;
`endif
    vec16_t t16 [NV16];
    vec10_t t10 [4];

    initial begin
        int lat;
        logic [15:0] held;

        t16[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        t16[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        t16[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        t16[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        t16[4] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        t16[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        t16[6] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        t16[7] = '{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0};
`ifdef CHUNK_ADDER_SUB_EN
        t16[8]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        t16[9]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        t16[10] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
`endif
        t10[0] = '{10'h3FF, 10'h001, 1'b0, 10'h000, 1'b1, 1'b0};
        t10[1] = '{10'h1FF, 10'h001, 1'b0, 10'h200, 1'b0, 1'b1};
        t10[2] = '{10'h2AA, 10'h155, 1'b1, 10'h000, 1'b1, 1'b0};
        t10[3] = '{10'h200, 10'h200, 1'b0, 10'h000, 1'b1, 1'b1};

        // reset state
        #12;
        chk("rst in_ready",  {31'd0, r16},  0);
        chk("rst out_valid", {31'd0, ov16}, 0);
        chk("rst sum",       {16'd0, sum16}, 0);
        chk("rst cout",      {31'd0, co16}, 0);
        chk("rst overflow",  {31'd0, of16}, 0);
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        for (int i = 0; i < NV16; i++) begin
            op16(t16[i].a, t16[i].b, t16[i].cin, t16[i].sub, lat);
            chk($sformatf("v16[%0d] latency", i), lat, 4);
            chk($sformatf("v16[%0d] sum", i), {16'd0, sum16}, {16'd0, t16[i].sum});
            chk($sformatf("v16[%0d] cout", i), {31'd0, co16}, {31'd0, t16[i].cout});
            chk($sformatf("v16[%0d] ovf", i), {31'd0, of16}, {31'd0, t16[i].ovf});
            drain16();
        end

        for (int i = 0; i < 4; i++) begin
            op10(t10[i].a, t10[i].b, t10[i].cin, lat);
            chk($sformatf("v10[%0d] latency", i), lat, 3);
            chk($sformatf("v10[%0d] sum", i), {22'd0, sum10}, {22'd0, t10[i].sum});
            chk($sformatf("v10[%0d] cout", i), {31'd0, co10}, {31'd0, t10[i].cout});
            chk($sformatf("v10[%0d] ovf", i), {31'd0, of10}, {31'd0, t10[i].ovf});
            drain10();
        end

        // backpressure: result holds, in_ready low, in_valid pulses ignored
        op16(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
        held = sum16;
        chk("bp first sum", {16'd0, held}, 32'h3333);
        for (int k = 0; k < 5; k++) begin
            v16 = k[0]; a16 = 16'h0F0F; b16 = 16'h0101;
            @(posedge clk); #1;
            chk("bp out_valid", {31'd0, ov16}, 1);
            chk("bp in_ready", {31'd0, r16}, 0);
            chk("bp sum", {16'd0, sum16}, 32'h3333);
            chk("bp cout", {31'd0, co16}, 0);
        end
        v16 = 0;
        drain16();
        chk("release in_ready", {31'd0, r16}, 1);
        chk("release out_valid", {31'd0, ov16}, 0);
        op16(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
        chk("after bp sum", {16'd0, sum16}, 32'h0002);
        chk("after bp latency", lat, 4);
        drain16();

        // reset in the middle of RUN
        while (!r16) begin @(posedge clk); #1; end
        a16 = 16'hFFFF; b16 = 16'h0001; c16 = 0; s16 = 0; v16 = 1;
        @(posedge clk); #1; v16 = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1; #1;
        chk("midrst out_valid", {31'd0, ov16}, 0);
        chk("midrst in_ready", {31'd0, r16}, 0);
        chk("midrst sum", {16'd0, sum16}, 0);
        chk("midrst cout", {31'd0, co16}, 0);
        @(posedge clk); @(posedge clk); #1;
        chk("midrst no valid", {31'd0, ov16}, 0);
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        op16(16'h0003, 16'h0004, 1'b0, 1'b0, lat);
        chk("post rst sum", {16'd0, sum16}, 32'h0007);
        chk("post rst latency", lat, 4);
        drain16();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
